jk_ff_bank: RTL and testbench
=============================

# jk_ff_bank

Parametrised bank of WIDTH JK-style flip-flops sharing one clock. Each bit runs in a runtime-selectable mode (JK, T, D, SR), with parallel load and a clock enable. Per-bit sticky change flags and a sticky SR-illegal flag are provided. The block replaces single-bit JK registers wherever a datapath needs control or status bits with set, clear and toggle semantics.

## Interface
- WIDTH, 8, number of flip-flops in the bank (≥1)
- CNT_W, 16, width of the optional change-event counter (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  clock enable for J/K/mode updates
- mode  in  2  operating mode for all bits (jk_mode_t)
- j  in  WIDTH  J / T / D / S input, per bit
- k  in  WIDTH  K / R input, per bit (ignored in T and D)
- load  in  1  parallel load strobe
- d  in  WIDTH  parallel load data
- clr_status  in  1  clears changed, err and event_cnt
- q  out  WIDTH  register state
- q_bar  out  WIDTH  ~q, combinational
- changed  out  WIDTH  sticky: bit i changed value since last clear
- err  out  1  sticky: SR mode saw S=R=1 on some bit while enabled
- event_cnt  out  CNT_W  saturating count of cycles in which q changed (only with JK_FF_BANK_CNT_EN)

## Operation
- Priority per edge: rst low > load > en > hold.
- rst low: q, changed, err and event_cnt go to 0. load, en and clr_status are ignored.
- load=1: q ← d regardless of en and mode. The SR error check does not run in a load cycle.
- en=1, load=0, per bit i:
  - MODE_JK (00): 00 hold, 01 clear, 10 set, 11 toggle.
  - MODE_T (01): j[i]=1 toggles q[i]; j[i]=0 holds.
  - MODE_D (10): q[i] ← j[i].
  - MODE_SR (11): S=j, R=k. 10 set, 01 clear, 00 hold. 11 holds q[i] and sets err.
- en=0, load=0: q holds. No err is generated.
- changed[i] ← 1 when the next q[i] differs from the current q[i], whatever the cause (including load).
- clr_status=1 clears changed, err and event_cnt.
- If clr_status and a new event (change or SR error) occur on the same edge, the new event survives. The flag ends at 1, and event_cnt ends at 1.
- event_cnt increments by 1 in each cycle where any bit of q changes. It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Single-cycle latency: inputs sampled at edge N appear on q, changed, err and event_cnt after edge N.
- q_bar follows q combinationally with zero added cycles.
- Reset values: q=0, q_bar=all-ones, changed=0, err=0, event_cnt=0.
- Reset asserted mid-operation takes effect at the next edge and discards any pending load or mode activity.
- A mode change takes effect on the same edge it is sampled. There is no pipeline and no state tied to the previous mode.
- No handshake. Inputs must be stable around the rising clk edge.

## Configuration
- JK_FF_BANK_CNT_EN defined: event_cnt port and the counter register are present, with the behaviour above.
- JK_FF_BANK_CNT_EN undefined: event_cnt port and the counter are absent. All other behaviour is identical.

## Structure
- Package jk_ff_pkg:
  - typedef enum logic [1:0] jk_mode_t: MODE_JK=0, MODE_T=1, MODE_D=2, MODE_SR=3.
  - Pure function jk_next(mode, q, j, k), returning the next bit and an illegal flag.
- Sub-module jk_ff_bank_cell, instantiated WIDTH times:
  - Contains one flip-flop, its changed flag and its local SR-illegal output.
- Top level of jk_ff_bank:
  - ORs the per-cell illegal outputs into err.
  - ORs the per-cell change strobes into the event_cnt increment.

## Test plan
- Reset: drive rst=0 for 2 cycles with load=1, d=8'hFF. Required: q=8'h00, q_bar=8'hFF, changed=0, err=0, event_cnt=0.
- JK modes: q=8'h0F, mode=JK, en=1, j=8'hF0, k=8'h3C. Required next q=8'hF3 (set 7:6, toggle 5:4 to 1, clear 3:2, hold 1:0). Required changed=8'hFC.
- T and D: q=8'hA5, mode=T, j=8'hFF gives q=8'h5A. Then mode=D, j=8'h3C gives q=8'h3C. With en=0, q holds 8'h3C for 3 cycles.
- SR illegal: mode=SR, j=8'h81, k=8'h01 from q=8'h00. Required q=8'h80 and err=1. With clr_status=1 and en=0, err returns to 0 next cycle. A clr_status coinciding with a new S=R=1 leaves err=1.
- Load priority: en=1, mode=JK, j=k=8'hFF, load=1, d=8'h42. Required q=8'h42 (load wins over toggle).
- Counter (CNT_W=2, macro defined): toggle bit 0 for 5 cycles. Required event_cnt sequence 1,2,3,3,3. A clr_status during a toggle gives event_cnt=1. With the macro undefined, build with the port absent and all other checks passing.

Source files
------------

// File: rtl/jk_ff_pkg.sv
// rtl/jk_ff_pkg.sv - shared types and next-state function for the JK flip-flop bank
//
// Purpose: mode encoding and the per-bit next-state rule used by every cell.
// Contents:
//   jk_mode_t  - operating mode for the whole bank
//   jk_next_t  - next bit value plus SR-illegal indication
//   jk_next()  - pure next-state function for one bit
package jk_ff_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'd0,
    MODE_T  = 2'd1,
    MODE_D  = 2'd2,
    MODE_SR = 2'd3
  } jk_mode_t;

  typedef struct packed {
    logic q;
    logic illegal;
  } jk_next_t;

  // In T and D modes k is a don't-care; j carries the T or D input.
  function automatic jk_next_t jk_next(input jk_mode_t mode, input logic q,
                                       input logic j, input logic k);
    jk_next_t r;
    r.q       = q;
    r.illegal = 1'b0;
    unique case (mode)
      MODE_JK: begin
        unique case ({j, k})
          2'b00:   r.q = q;
          2'b01:   r.q = 1'b0;
          2'b10:   r.q = 1'b1;
          default: r.q = ~q;
        endcase
      end
      MODE_T:  r.q = j ? ~q : q;
      MODE_D:  r.q = j;
      default: begin
        // S=R=1 is undefined for a real SR latch: hold the bit and report it.
        unique case ({j, k})
          2'b10:   r.q = 1'b1;
          2'b01:   r.q = 1'b0;
          2'b00:   r.q = q;
          default: begin
            r.q       = q;
            r.illegal = 1'b1;
          end
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_ff_bank_cell.sv
// rtl/jk_ff_bank_cell.sv - one flip-flop of the bank with its sticky change flag
//
// Purpose: holds one state bit, its sticky changed flag, and reports
// per-cycle change and SR-illegal strobes to the bank.
// Ports:
//   clk, rst         - clock, synchronous active-low reset
//   en, load, mode   - update enable, parallel-load strobe, operating mode
//   j, k, d          - mode inputs and parallel-load data for this bit
//   clr_status       - clears the sticky changed flag
//   q                - state bit
//   changed          - sticky: q changed since last clear
//   change_stb       - q is about to change on this edge
//   illegal          - SR mode with S=R=1 is being applied on this edge
module jk_ff_bank_cell
  import jk_ff_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     load,
  input  jk_mode_t mode,
  input  logic     j,
  input  logic     k,
  input  logic     d,
  input  logic     clr_status,
  output logic     q,
  output logic     changed,
  output logic     change_stb,
  output logic     illegal
);

  logic     q_q, q_d;
  logic     changed_q, changed_d;
  jk_next_t nxt;

  always_comb begin
    nxt        = jk_next(mode, q_q, j, k);
    q_d        = q_q;
    illegal    = 1'b0;
    if (load) begin
      // A load bypasses the mode logic entirely, so no SR check either.
      q_d = d;
    end else if (en) begin
      q_d     = nxt.q;
      illegal = nxt.illegal;
    end
    change_stb = (q_d != q_q);
    // A new change on the clearing edge wins over the clear.
    changed_d  = (changed_q & ~clr_status) | change_stb;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q       <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  assign changed = changed_q;

endmodule

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - bank of mode-selectable JK flip-flops with sticky status
//
// Purpose: WIDTH flip-flops sharing clock, mode, enable and load; sticky
// per-bit change flags, a sticky SR-illegal flag and, when
// JK_FF_BANK_CNT_EN is defined, a saturating change-event counter.
// Parameters: WIDTH (>=1) bank width, CNT_W (>=2) event counter width.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   en, mode, j, k      - update enable, mode, per-bit J/T/D/S and K/R inputs
//   load, d             - parallel load strobe and data (beats en)
//   clr_status          - clears changed, err and event_cnt
//   q, q_bar            - state and its combinational complement
//   changed, err        - sticky per-bit change flags, sticky SR-illegal flag
//   event_cnt           - cycles in which q changed (JK_FF_BANK_CNT_EN only)
module jk_ff_bank
  import jk_ff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  jk_mode_t         mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             clr_status,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] changed,
`ifdef JK_FF_BANK_CNT_EN
  output logic [CNT_W-1:0] event_cnt,
`endif
  output logic             err
);

  if (WIDTH < 1 || CNT_W < 2) begin : g_bad_params
    $error("jk_ff_bank: WIDTH must be >=1 and CNT_W >=2");
  end

  logic [WIDTH-1:0] change_stb;
  logic [WIDTH-1:0] illegal;
  logic             any_change;
  logic             err_q, err_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_bank_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .load       (load),
      .mode       (mode),
      .j          (j[i]),
      .k          (k[i]),
      .d          (d[i]),
      .clr_status (clr_status),
      .q          (q[i]),
      .changed    (changed[i]),
      .change_stb (change_stb[i]),
      .illegal    (illegal[i])
    );
  end

  assign q_bar      = ~q;
  assign any_change = |change_stb;

  always_comb begin
    err_d = (err_q & ~clr_status) | (|illegal);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

`ifdef JK_FF_BANK_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_status) begin
      // The change on a clearing edge is counted as the first new event.
      cnt_d = any_change ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (any_change && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign event_cnt = cnt_q;
`else
  logic unused_any_change;
  assign unused_any_change = any_change;
`endif

endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - scoreboard testbench for jk_ff_bank
module tb_jk_ff_bank;
  import jk_ff_pkg::*;

  localparam int W  = 8;
  localparam int CW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  jk_mode_t     mode;
  logic [W-1:0] j, k, d;
  logic         load;
  logic         clr_status;
  logic [W-1:0] q, q_bar, changed;
  logic         err;
`ifdef JK_FF_BANK_CNT_EN
  logic [CW-1:0] event_cnt;
`endif

  always #5 clk = ~clk;

  jk_ff_bank #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .j          (j),
    .k          (k),
    .load       (load),
    .d          (d),
    .clr_status (clr_status),
    .q          (q),
    .q_bar      (q_bar),
    .changed    (changed),
`ifdef JK_FF_BANK_CNT_EN
    .event_cnt  (event_cnt),
`endif
    .err        (err)
  );

  typedef struct {
    int           id;
    logic [W-1:0] q;
    logic [W-1:0] chg;
    logic         err;
    logic [1:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_id  = 0;

  task automatic chk(input int id, input string name, input logic [15:0] got,
                     input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL step%0d %s: got %h want %h", id, name, got, want);
    end
  endtask

  // Monitor: the DUT presents a new result after every edge; pop one
  // expectation per edge whenever one is pending.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "q",       {8'h0, q},       {8'h0, e.q});
      chk(e.id, "q_bar",   {8'h0, q_bar},   {8'h0, ~e.q});
      chk(e.id, "changed", {8'h0, changed}, {8'h0, e.chg});
      chk(e.id, "err",     {15'h0, err},    {15'h0, e.err});
`ifdef JK_FF_BANK_CNT_EN
      chk(e.id, "event_cnt", {14'h0, event_cnt}, {14'h0, e.cnt});
`endif
    end
  end

  task automatic step(input logic r, input logic l, input logic [W-1:0] dd,
                      input logic e, input jk_mode_t m, input logic [W-1:0] jj,
                      input logic [W-1:0] kk, input logic c,
                      input logic [W-1:0] eq, input logic [W-1:0] echg,
                      input logic eerr, input logic [1:0] ecnt);
    exp_t x;
    rst = r; load = l; d = dd; en = e; mode = m; j = jj; k = kk; clr_status = c;
    step_id++;
    x.id = step_id; x.q = eq; x.chg = echg; x.err = eerr; x.cnt = ecnt;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst = 1'b0; load = 1'b0; d = '0; en = 1'b0; mode = MODE_JK;
    j = '0; k = '0; clr_status = 1'b0;
    @(negedge clk);
    //    rst  ld  d      en  mode     j      k      clr   q      chg    err  cnt
    // reset dominates a pending load
    step(1'b0, 1'b1, 8'hFF, 1'b1, MODE_JK, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
    step(1'b0, 1'b1, 8'hFF, 1'b1, MODE_JK, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);
    step(1'b1, 1'b1, 8'h0F, 1'b0, MODE_JK, 8'h00, 8'h00, 1'b0, 8'h0F, 8'h0F, 1'b0, 2'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0, MODE_JK, 8'h00, 8'h00, 1'b1, 8'h0F, 8'h00, 1'b0, 2'd0);
    // JK: set 7:6, toggle 5:4, clear 3:2, hold 1:0
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_JK, 8'hF0, 8'h3C, 1'b0, 8'hF3, 8'hFC, 1'b0, 2'd1);
    // load with clear: new changes survive the clear
    step(1'b1, 1'b1, 8'hA5, 1'b0, MODE_JK, 8'h00, 8'h00, 1'b1, 8'hA5, 8'h56, 1'b0, 2'd1);
    // T mode toggles all
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'hFF, 8'h00, 1'b1, 8'h5A, 8'hFF, 1'b0, 2'd1);
    // D mode
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_D,  8'h3C, 8'h00, 1'b0, 8'h3C, 8'hFF, 1'b0, 2'd2);
    // en=0 holds for 3 cycles, SR S=R=1 while disabled gives no err
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 8'h00, 1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b0, 8'h3C, 8'hFF, 1'b0, 2'd2);
    step(1'b1, 1'b1, 8'h00, 1'b0, MODE_JK, 8'h00, 8'h00, 1'b1, 8'h00, 8'h3C, 1'b0, 2'd1);
    // SR: bit7 set, bit0 illegal
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_SR, 8'h81, 8'h01, 1'b0, 8'h80, 8'hBC, 1'b1, 2'd2);
    step(1'b1, 1'b0, 8'h00, 1'b0, MODE_SR, 8'h81, 8'h01, 1'b1, 8'h80, 8'h00, 1'b0, 2'd0);
    // clear coinciding with a new illegal: err survives
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_SR, 8'h81, 8'h01, 1'b1, 8'h80, 8'h00, 1'b1, 2'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0, MODE_SR, 8'h00, 8'h00, 1'b0, 8'h80, 8'h00, 1'b1, 2'd0);
    // SR reset of bit7 with clear
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_SR, 8'h00, 8'h80, 1'b1, 8'h00, 8'h80, 1'b0, 2'd1);
    // load beats JK toggle
    step(1'b1, 1'b1, 8'h42, 1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0, 8'h42, 8'hC2, 1'b0, 2'd2);
    // load cycle suppresses the SR check
    step(1'b1, 1'b1, 8'h42, 1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b0, 8'h42, 8'hC2, 1'b0, 2'd2);
    step(1'b1, 1'b0, 8'h00, 1'b0, MODE_JK, 8'h00, 8'h00, 1'b1, 8'h42, 8'h00, 1'b0, 2'd0);
    // counter saturation at 3 while toggling bit 0
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'h01, 8'h00, 1'b0, 8'h43, 8'h01, 1'b0, 2'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'h01, 8'h00, 1'b0, 8'h42, 8'h01, 1'b0, 2'd2);
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'h01, 8'h00, 1'b0, 8'h43, 8'h01, 1'b0, 2'd3);
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'h01, 8'h00, 1'b0, 8'h42, 8'h01, 1'b0, 2'd3);
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'h01, 8'h00, 1'b0, 8'h43, 8'h01, 1'b0, 2'd3);
    // clear during a toggle restarts count at 1
    step(1'b1, 1'b0, 8'h00, 1'b1, MODE_T,  8'h01, 8'h00, 1'b1, 8'h42, 8'h01, 1'b0, 2'd1);
    // mid-operation reset discards pending load and toggle
    step(1'b0, 1'b1, 8'hFF, 1'b1, MODE_T,  8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 2'd0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
